// File: rtl/ddr2_port_arbiter.sv
// Round-robin front end that serialises CHANNELS client requests onto the single DDR2 request port.
// Optional watchdog on the completion wait is enabled by defining DDR2_ARB_TIMEOUT_EN.
module ddr2_port_arbiter #(
  parameter int CHANNELS       = 2,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic [CHANNELS-1:0]        req_valid,
  output logic [CHANNELS-1:0]        req_ready,
  input  logic [CHANNELS-1:0]        req_we,
  input  logic [CHANNELS*ADDR_W-1:0] req_addr,
  input  logic [CHANNELS*DATA_W-1:0] req_wd,
  output logic [CHANNELS-1:0]        resp_valid,
  output logic [DATA_W-1:0]          resp_rd,
  output logic                       resp_err,
  output logic                       busy,
  input  logic                       ddr2_stall,
  input  logic [DATA_W-1:0]          ddr2_rd,
  output logic                       ddr2_en,
  output logic                       ddr2_we,
  output logic [ADDR_W-1:0]          ddr2_addr,
  output logic [DATA_W-1:0]          ddr2_wd
);

  localparam int IDX_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int WD_LIMIT = (TIMEOUT_CYCLES > 1) ? (TIMEOUT_CYCLES - 1) : 0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t                r_state;
  logic [IDX_W-1:0]      r_last;
  logic                  r_ddr2_en;
  logic                  r_ddr2_we;
  logic [ADDR_W-1:0]     r_ddr2_addr;
  logic [DATA_W-1:0]     r_ddr2_wd;
  logic [CHANNELS-1:0]   r_resp_valid;
  logic [DATA_W-1:0]     r_resp_rd;
  logic                  r_busy;

  logic                  w_gnt_any;
  logic [IDX_W-1:0]      w_gnt_idx;
  logic [IDX_W-1:0]      w_probe;
  logic [CHANNELS-1:0]   w_owner_onehot;
  logic                  w_timeout;
  logic                  w_complete;

  // Round-robin search starting one past the last granted channel.
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = r_last;
    w_probe   = r_last;
    for (int k = 1; k <= CHANNELS; k++) begin
      w_probe = IDX_W'((int'(r_last) + k) % CHANNELS);
      if (!w_gnt_any && req_valid[w_probe]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = w_probe;
      end else begin
        w_gnt_any = w_gnt_any;
      end
    end
  end

  // Ready is the only combinational output: it marks the capture edge for the client.
  always_comb begin
    req_ready = '0;
    if ((r_state == S_IDLE) && w_gnt_any) begin
      req_ready[w_gnt_idx] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  // Response routing uses the registered owner of the outstanding transaction.
  always_comb begin
    w_owner_onehot = CHANNELS'(1'b1) << r_last;
  end

  assign w_complete = (r_state == S_WAIT) && (!ddr2_stall || w_timeout);

`ifdef DDR2_ARB_TIMEOUT_EN
  logic [31:0] r_wd_cnt;
  logic        r_resp_err;

  assign w_timeout = (r_state == S_WAIT) && ddr2_stall && (r_wd_cnt >= 32'(WD_LIMIT));
  assign resp_err  = r_resp_err;

  // Watchdog counts stalled WAIT cycles; the error flag follows each response.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_wd_cnt   <= 32'd0;
      r_resp_err <= 1'b0;
    end else begin
      if ((r_state == S_ISSUE) && !ddr2_stall) begin
        r_wd_cnt <= 32'd0;
      end else if ((r_state == S_WAIT) && ddr2_stall) begin
        r_wd_cnt <= r_wd_cnt + 32'd1;
      end else begin
        r_wd_cnt <= r_wd_cnt;
      end
      if (w_complete) begin
        r_resp_err <= w_timeout;
      end else begin
        r_resp_err <= r_resp_err;
      end
    end
  end
`else
  assign w_timeout = (WD_LIMIT < 0);
  assign resp_err  = 1'b0;
`endif

  // Main transaction FSM with all port-side outputs registered.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_last       <= IDX_W'(CHANNELS - 1);
      r_ddr2_en    <= 1'b0;
      r_ddr2_we    <= 1'b0;
      r_ddr2_addr  <= '0;
      r_ddr2_wd    <= '0;
      r_resp_valid <= '0;
      r_resp_rd    <= '0;
      r_busy       <= 1'b0;
    end else begin
      r_resp_valid <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_gnt_any) begin
            r_state     <= S_ISSUE;
            r_last      <= w_gnt_idx;
            r_ddr2_en   <= 1'b1;
            r_ddr2_we   <= req_we[w_gnt_idx];
            r_ddr2_addr <= req_addr[w_gnt_idx*ADDR_W +: ADDR_W];
            r_ddr2_wd   <= req_wd[w_gnt_idx*DATA_W +: DATA_W];
            r_busy      <= 1'b1;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_ISSUE: begin
          if (!ddr2_stall) begin
            r_ddr2_en <= 1'b0;
            r_state   <= S_WAIT;
          end else begin
            r_state <= S_ISSUE;
          end
        end
        S_WAIT: begin
          if (w_complete) begin
            r_resp_valid <= w_owner_onehot;
            r_state      <= S_IDLE;
            r_busy       <= 1'b0;
            // A watchdog abort leaves the last read data untouched.
            if (!r_ddr2_we && !w_timeout) begin
              r_resp_rd <= ddr2_rd;
            end else begin
              r_resp_rd <= r_resp_rd;
            end
          end else begin
            r_state <= S_WAIT;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_ddr2_en <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign ddr2_en    = r_ddr2_en;
  assign ddr2_we    = r_ddr2_we;
  assign ddr2_addr  = r_ddr2_addr;
  assign ddr2_wd    = r_ddr2_wd;
  assign resp_valid = r_resp_valid;
  assign resp_rd    = r_resp_rd;
  assign busy       = r_busy;

endmodule

// File: doc/ddr2_port_arbiter.md
# ddr2_port_arbiter

Multi-channel front end for the DDR2 request port: accepts independent read/write requests from `CHANNELS` clients and serialises them onto the single `ddr2_en/we/addr/wd/rd/stall` interface. Arbitration is round-robin, and one transaction is outstanding at a time. Each request gets exactly one response pulse routed back to its own channel. The block sits between the CPU-side clients (instruction fetch, data access, UART DMA) and the DDR2 controller, replacing the single-master direct connection.

## Interface
- `CHANNELS`, 2, number of client channels (1..8)
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `TIMEOUT_CYCLES`, 1024, watchdog limit in cycles (used only with the macro)

Ports:
- `clock`  in  1  sole clock, rising edge
- `resetn`  in  1  asynchronous, active-low reset
- `req_valid`  in  CHANNELS  per-channel request present
- `req_ready`  out  CHANNELS  one-hot; request of that channel captured this cycle
- `req_we`  in  CHANNELS  1 = write, 0 = read
- `req_addr`  in  CHANNELS*ADDR_W  channel i at bits [i*ADDR_W +: ADDR_W]
- `req_wd`  in  CHANNELS*DATA_W  channel i at bits [i*DATA_W +: DATA_W]
- `resp_valid`  out  CHANNELS  one-cycle pulse to the requesting channel
- `resp_rd`  out  DATA_W  read data, shared, valid with `resp_valid`
- `resp_err`  out  1  response aborted by watchdog (tied 0 without macro)
- `busy`  out  1  state ≠ IDLE
- `ddr2_stall`  in  1  controller not accepting / transaction in progress
- `ddr2_rd`  in  DATA_W  read data from controller
- `ddr2_en`  out  1  request strobe
- `ddr2_we`  out  1  write enable
- `ddr2_addr`  out  ADDR_W  address
- `ddr2_wd`  out  DATA_W  write data

## Operation
- FSM: IDLE → ISSUE → WAIT → IDLE.
- IDLE: if any `req_valid`, grant the first requesting channel searching from `last+1` (mod CHANNELS). Assert its `req_ready` combinationally this cycle. At the edge, capture we/addr/wd into the `ddr2_*` output registers, set `last` = granted index, and go to ISSUE.
- ISSUE: `ddr2_en`=1. A request is accepted at an edge where `ddr2_en`=1 and `ddr2_stall`=0. On acceptance, drop `ddr2_en` and go to WAIT. While the controller stalls, hold everything.
- WAIT: completion is the first WAIT cycle with `ddr2_stall`=0. At that edge:
  - if read, latch `ddr2_rd` into `resp_rd`;
  - register a `resp_valid` pulse for the granted channel;
  - go to IDLE.
- `resp_valid` is high in the first IDLE cycle. A new grant in that same cycle is allowed.
- `ddr2_we/addr/wd` hold the captured values from ISSUE until the next grant.
- `resp_rd` holds the last read data. Writes do not change it.
- Requests not granted keep `req_valid` asserted. Clients must not change we/addr/wd while valid and not ready.
- CHANNELS=1 degenerates to a pass-through with the same FSM timing.

## Timing
- Reset values (async, on `resetn`=0):
  - state IDLE, `last`=CHANNELS-1 (channel 0 wins first);
  - all `ddr2_*` outputs 0, `resp_valid`=0, `resp_rd`=0, `resp_err`=0, `busy`=0.
- `req_ready` is the only combinational output. All others are registered.
- Minimum latency with zero stall:
  - grant in cycle t, `ddr2_en` high in t+1, completion sampled in t+2;
  - `resp_valid` high in t+3, next grant possible in t+3.
- Each stall cycle in ISSUE or WAIT adds one cycle.
- Reset mid-transaction: the outstanding request is dropped and no response is issued. Clients re-request after reset.

## Configuration
- Macro `DDR2_ARB_TIMEOUT_EN`.
- Defined: a counter increments each WAIT cycle with `ddr2_stall`=1 and clears on entering WAIT. When it reaches `TIMEOUT_CYCLES` in WAIT:
  - force completion with `resp_rd` unchanged;
  - set `resp_err`=1 together with that `resp_valid` pulse;
  - `resp_err` clears on the next response.
- Not defined: no counter, `resp_err` constant 0, WAIT lasts indefinitely.

## Test plan
- Single read, ch0, addr 0x100, stall never asserted → `ddr2_en` in cycle t+1; `resp_valid`=2'b01 in t+3 with `resp_rd`=`ddr2_rd` value 0xDEADBEEF sampled at t+2.
- Write on ch1, data 0x12345678, stall high 3 cycles after acceptance → `resp_valid`=2'b10 at t+6; `resp_rd` unchanged; `ddr2_wd`=0x12345678 held throughout.
- Both channels hold `req_valid` continuously for 6 transactions → grants alternate 0,1,0,1,0,1; exactly one `resp_valid` bit per response.
- Stall held high during ISSUE for 4 cycles → `ddr2_en` stays high 5 cycles; single acceptance; one response.
- `resetn` pulsed low while in WAIT → all outputs return to reset values immediately; no `resp_valid`; channel 0 granted first afterwards.
- With `DDR2_ARB_TIMEOUT_EN`, TIMEOUT_CYCLES=8, stall stuck high → `resp_valid` with `resp_err`=1 after 8 WAIT cycles; next normal read returns `resp_err`=0.
